// File: rtl/fa_bist_if.sv
// Stimulus/response link between the fa_bist sequencer and the full adder under test.
interface fa_bist_if;
   logic dut_a;
   logic dut_b;
   logic dut_cin;
   logic dut_s;
   logic dut_cout;

   modport master (output dut_a, output dut_b, output dut_cin, input dut_s, input dut_cout);
   modport slave  (input dut_a, input dut_b, input dut_cin, output dut_s, output dut_cout);
endinterface

// File: rtl/fa_bist.sv
// Exhaustive 8-vector self-test sequencer for a single full adder, all outputs registered.
// Optional per-vector failure bitmap port enabled with macro FA_BIST_FAILMAP_EN.
module fa_bist #(
   parameter int unsigned SETTLE = 2,
   parameter bit          LOOP   = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   fa_bist_if.master  fa,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] err_cnt,
   output logic [2:0] first_fail,
   output logic       first_fail_vld
`ifdef FA_BIST_FAILMAP_EN
   ,
   output logic [7:0] fail_map
`endif
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_APPLY = 3'd1,
      S_WAIT  = 3'd2,
      S_CHECK = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam logic [3:0] SETTLE_M1 = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;

   state_t     state_r, state_s;
   logic [2:0] vec_r, vec_s;
   logic [3:0] wait_r, wait_s;
   logic [2:0] dut_vec_r, dut_vec_s;
   logic       busy_r, busy_s;
   logic       done_r, done_s;
   logic       pass_r, pass_s;
   logic [3:0] err_r, err_s;
   logic [2:0] ff_r, ff_s;
   logic       ffv_r, ffv_s;
   logic       exp_sum_s, exp_cout_s, mismatch_s;
`ifdef FA_BIST_FAILMAP_EN
   logic [7:0] map_r, map_s;
`endif

   // Reference full-adder response for the vector currently on the pins.
   always_comb begin
      exp_sum_s  = ^vec_r;
      exp_cout_s = (vec_r[2] & vec_r[1]) | (vec_r[2] & vec_r[0]) | (vec_r[1] & vec_r[0]);
      mismatch_s = (fa.dut_s != exp_sum_s) || (fa.dut_cout != exp_cout_s);
   end

   // Next-state, result bookkeeping and next registered output values.
   always_comb begin
      state_s = state_r;
      vec_s   = vec_r;
      wait_s  = wait_r;
      pass_s  = pass_r;
      err_s   = err_r;
      ff_s    = ff_r;
      ffv_s   = ffv_r;
`ifdef FA_BIST_FAILMAP_EN
      map_s   = map_r;
`endif
      case (state_r)
         S_IDLE: begin
            if (start) begin
               state_s = S_APPLY;
               vec_s   = 3'd0;
               wait_s  = 4'd0;
               pass_s  = 1'b0;
               err_s   = 4'd0;
               ff_s    = 3'd0;
               ffv_s   = 1'b0;
`ifdef FA_BIST_FAILMAP_EN
               map_s   = 8'h00;
`endif
            end else begin
               state_s = S_IDLE;
            end
         end
         S_APPLY: begin
            wait_s = 4'd0;
            if (SETTLE == 0) begin
               state_s = S_CHECK;
            end else begin
               state_s = S_WAIT;
            end
         end
         S_WAIT: begin
            if (wait_r == SETTLE_M1) begin
               state_s = S_CHECK;
               wait_s  = 4'd0;
            end else begin
               wait_s  = wait_r + 4'd1;
            end
         end
         S_CHECK: begin
            if (mismatch_s) begin
               err_s = err_r + 4'd1;
`ifdef FA_BIST_FAILMAP_EN
               map_s[vec_r] = 1'b1;
`endif
               if (!ffv_r) begin
                  ff_s  = vec_r;
                  ffv_s = 1'b1;
               end else begin
                  ff_s  = ff_r;
               end
            end else begin
               err_s = err_r;
            end
            if (vec_r == 3'd7) begin
               state_s = S_DONE;
               pass_s  = (err_s == 4'd0);
            end else begin
               state_s = S_APPLY;
               vec_s   = vec_r + 3'd1;
            end
         end
         S_DONE: begin
            if (LOOP) begin
               state_s = S_APPLY;
               vec_s   = 3'd0;
               pass_s  = 1'b0;
               err_s   = 4'd0;
               ff_s    = 3'd0;
               ffv_s   = 1'b0;
`ifdef FA_BIST_FAILMAP_EN
               map_s   = 8'h00;
`endif
            end else begin
               state_s = S_IDLE;
            end
         end
         default: begin
            state_s = S_IDLE;
            vec_s   = 3'd0;
            wait_s  = 4'd0;
         end
      endcase

      busy_s    = (state_s == S_APPLY) || (state_s == S_WAIT) || (state_s == S_CHECK);
      done_s    = (state_s == S_DONE);
      dut_vec_s = busy_s ? vec_s : 3'd0;
   end

   // State and registered outputs; reset abandons any sweep without a done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= S_IDLE;
         vec_r     <= 3'd0;
         wait_r    <= 4'd0;
         dut_vec_r <= 3'd0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         pass_r    <= 1'b0;
         err_r     <= 4'd0;
         ff_r      <= 3'd0;
         ffv_r     <= 1'b0;
`ifdef FA_BIST_FAILMAP_EN
         map_r     <= 8'h00;
`endif
      end else begin
         state_r   <= state_s;
         vec_r     <= vec_s;
         wait_r    <= wait_s;
         dut_vec_r <= dut_vec_s;
         busy_r    <= busy_s;
         done_r    <= done_s;
         pass_r    <= pass_s;
         err_r     <= err_s;
         ff_r      <= ff_s;
         ffv_r     <= ffv_s;
`ifdef FA_BIST_FAILMAP_EN
         map_r     <= map_s;
`endif
      end
   end

   assign fa.dut_a       = dut_vec_r[2];
   assign fa.dut_b       = dut_vec_r[1];
   assign fa.dut_cin     = dut_vec_r[0];
   assign busy           = busy_r;
   assign done           = done_r;
   assign pass           = pass_r;
   assign err_cnt        = err_r;
   assign first_fail     = ff_r;
   assign first_fail_vld = ffv_r;
`ifdef FA_BIST_FAILMAP_EN
   assign fail_map       = map_r;
`endif

endmodule

// File: tb/tb_fa_bist.sv
// Directed bench for fa_bist: three instances (SETTLE=2, SETTLE=0, SETTLE=2 with LOOP).
module tb_fa_bist;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] start_v;
   logic [2:0] busy_v, done_v, pass_v, ffv_v;
   logic [3:0] err_v [3];
   logic [2:0] ff_v [3];
`ifdef FA_BIST_FAILMAP_EN
   logic [7:0] map_v [3];
`endif
   int mode;
   int nchk = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   fa_bist_if fa0 ();
   fa_bist_if fa1 ();
   fa_bist_if fa2 ();

   // Adder under test with selectable faults: 1 s stuck0, 2 cout inv, 3 s inv, 4 cout stuck0, 5 cout stuck1
   function automatic logic model_s(input logic a, input logic b, input logic c, input int m);
      case (m)
         1:       return 1'b0;
         3:       return ~(a ^ b ^ c);
         default: return a ^ b ^ c;
      endcase
   endfunction

   function automatic logic model_c(input logic a, input logic b, input logic c, input int m);
      logic maj;
      maj = (a & b) | (a & c) | (b & c);
      case (m)
         2:       return ~maj;
         4:       return 1'b0;
         5:       return 1'b1;
         default: return maj;
      endcase
   endfunction

   assign fa0.dut_s    = model_s(fa0.dut_a, fa0.dut_b, fa0.dut_cin, mode);
   assign fa0.dut_cout = model_c(fa0.dut_a, fa0.dut_b, fa0.dut_cin, mode);
   assign fa1.dut_s    = model_s(fa1.dut_a, fa1.dut_b, fa1.dut_cin, mode);
   assign fa1.dut_cout = model_c(fa1.dut_a, fa1.dut_b, fa1.dut_cin, mode);
   assign fa2.dut_s    = model_s(fa2.dut_a, fa2.dut_b, fa2.dut_cin, mode);
   assign fa2.dut_cout = model_c(fa2.dut_a, fa2.dut_b, fa2.dut_cin, mode);

   fa_bist #(.SETTLE(2), .LOOP(1'b0)) u0 (
      .clk(clk), .rst(rst), .start(start_v[0]), .fa(fa0.master),
      .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .err_cnt(err_v[0]),
      .first_fail(ff_v[0]), .first_fail_vld(ffv_v[0])
`ifdef FA_BIST_FAILMAP_EN
      , .fail_map(map_v[0])
`endif
   );

   fa_bist #(.SETTLE(0), .LOOP(1'b0)) u1 (
      .clk(clk), .rst(rst), .start(start_v[1]), .fa(fa1.master),
      .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .err_cnt(err_v[1]),
      .first_fail(ff_v[1]), .first_fail_vld(ffv_v[1])
`ifdef FA_BIST_FAILMAP_EN
      , .fail_map(map_v[1])
`endif
   );

   fa_bist #(.SETTLE(2), .LOOP(1'b1)) u2 (
      .clk(clk), .rst(rst), .start(start_v[2]), .fa(fa2.master),
      .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .err_cnt(err_v[2]),
      .first_fail(ff_v[2]), .first_fail_vld(ffv_v[2])
`ifdef FA_BIST_FAILMAP_EN
      , .fail_map(map_v[2])
`endif
   );

   task automatic chk(input string name, input int act, input int exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int pins(input int k);
      case (k)
         0:       return {fa0.dut_a, fa0.dut_b, fa0.dut_cin};
         1:       return {fa1.dut_a, fa1.dut_b, fa1.dut_cin};
         default: return {fa2.dut_a, fa2.dut_b, fa2.dut_cin};
      endcase
   endfunction

   // Pulse start on instance k; cyc = cycle (1 = first after sampling edge) at which done is seen.
   // Optionally re-pulses start at cycle rp to show it is ignored while busy.
   task automatic sweep(input int k, input int rp, output int cyc, output int nbusy);
      @(negedge clk);
      start_v[k] = 1'b1;
      @(negedge clk);
      start_v[k] = 1'b0;
      cyc   = 1;
      nbusy = 0;
      while (!done_v[k] && cyc < 300) begin
         if (busy_v[k]) nbusy++;
         start_v[k] = (cyc == rp) ? 1'b1 : 1'b0;
         @(negedge clk);
         cyc++;
      end
      start_v[k] = 1'b0;
   endtask

   typedef struct {
      int mode;
      int exp_err;
      int exp_ff;
      int exp_ffv;
      int exp_pass;
      int exp_map;
   } vec_t;

   vec_t tbl[6];

   initial begin
      int cyc;
      int nb;
      int ndone;
      tbl[0] = '{0, 0, 0, 0, 1, 8'h00};
      tbl[1] = '{1, 4, 1, 1, 0, 8'h96};
      tbl[2] = '{2, 8, 0, 1, 0, 8'hFF};
      tbl[3] = '{3, 8, 0, 1, 0, 8'hFF};
      tbl[4] = '{4, 4, 3, 1, 0, 8'hE8};
      tbl[5] = '{5, 4, 0, 1, 0, 8'h17};

      mode    = 0;
      start_v = 3'b000;
      rst     = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("reset_busy", busy_v[0], 0);
      chk("reset_done", done_v[0], 0);
      chk("reset_err", err_v[0], 0);
      chk("reset_pins", pins(0), 0);

      // Table-driven sweeps on the SETTLE=2 instance
      for (int i = 0; i < 6; i++) begin
         mode = tbl[i].mode;
         sweep(0, 0, cyc, nb);
         chk($sformatf("t%0d_done_cycle", i), cyc, 33);
         chk($sformatf("t%0d_busy_cycles", i), nb, 32);
         chk($sformatf("t%0d_err_cnt", i), err_v[0], tbl[i].exp_err);
         chk($sformatf("t%0d_pass", i), pass_v[0], tbl[i].exp_pass);
         chk($sformatf("t%0d_ffv", i), ffv_v[0], tbl[i].exp_ffv);
         chk($sformatf("t%0d_ff", i), ff_v[0], tbl[i].exp_ff);
         chk($sformatf("t%0d_done_pins", i), pins(0), 0);
`ifdef FA_BIST_FAILMAP_EN
         chk($sformatf("t%0d_fail_map", i), map_v[0], tbl[i].exp_map);
`endif
         @(negedge clk);
         chk($sformatf("t%0d_done_pulse", i), done_v[0], 0);
         chk($sformatf("t%0d_hold_err", i), err_v[0], tbl[i].exp_err);
      end

      // Start re-pulsed mid-sweep is ignored
      mode = 0;
      sweep(0, 10, cyc, nb);
      chk("repulse_done_cycle", cyc, 33);
      chk("repulse_pass", pass_v[0], 1);

      // Reset while vector 3 is applied
      mode = 1;
      @(negedge clk);
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      repeat (13) @(negedge clk);
      chk("mid_pins_vec3", pins(0), 3);
      chk("mid_err", err_v[0], 2);
      chk("mid_ff", ff_v[0], 1);
      chk("mid_busy", busy_v[0], 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_busy", busy_v[0], 0);
      chk("rst_err", err_v[0], 0);
      chk("rst_ffv", ffv_v[0], 0);
      chk("rst_ff", ff_v[0], 0);
      chk("rst_pins", pins(0), 0);
      chk("rst_pass", pass_v[0], 0);
`ifdef FA_BIST_FAILMAP_EN
      chk("rst_fail_map", map_v[0], 0);
`endif
      ndone = 0;
      for (int i = 0; i < 60; i++) begin
         if (done_v[0] || busy_v[0]) ndone++;
         @(negedge clk);
      end
      chk("rst_no_done", ndone, 0);
      mode = 0;
      sweep(0, 0, cyc, nb);
      chk("post_rst_done_cycle", cyc, 33);
      chk("post_rst_pass", pass_v[0], 1);
      chk("post_rst_err", err_v[0], 0);

      // SETTLE=0 instance
      mode = 0;
      sweep(1, 0, cyc, nb);
      chk("s0_done_cycle", cyc, 17);
      chk("s0_busy_cycles", nb, 16);
      chk("s0_pass", pass_v[1], 1);
      mode = 2;
      sweep(1, 0, cyc, nb);
      chk("s0_inv_done_cycle", cyc, 17);
      chk("s0_inv_err", err_v[1], 8);
      chk("s0_inv_ff", ff_v[1], 0);
      chk("s0_inv_pass", pass_v[1], 0);

      // LOOP instance: one start, then periodic sweeps
      mode = 0;
      sweep(2, 0, cyc, nb);
      chk("loop_first_done", cyc, 33);
      chk("loop_first_pass", pass_v[2], 1);
      chk("loop_done_busy", busy_v[2], 0);
      for (int p = 0; p < 2; p++) begin
         @(negedge clk);
         cyc = 1;
         nb  = 0;
         while (!done_v[2] && cyc < 300) begin
            if (busy_v[2]) nb++;
            @(negedge clk);
            cyc++;
         end
         chk($sformatf("loop%0d_period", p), cyc, 33);
         chk($sformatf("loop%0d_busy_between", p), nb, 32);
         chk($sformatf("loop%0d_pass", p), pass_v[2], 1);
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
